rf_wb_queue: RTL
================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, data width of each register.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of register-file registers (power of 2).
REQ-003 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port wb_valid  input  1  producer offers a write-back.
REQ-007 SHALL have port wb_ready  output  1  queue can accept; equals !full.
REQ-008 SHALL have port wb_addr  input  $clog2(NUM_REGS)  destination register index.
REQ-009 SHALL have port wb_data  input  BUS_WIDTH  write-back data.
REQ-010 SHALL have port stall_in  input  1  register file busy; no write may issue.
REQ-011 SHALL have port regWrite  output  NUM_REGS  one-hot per-register write enables.
REQ-012 SHALL have port rf_in  output  BUS_WIDTH  shared data bus to all registers' in.
REQ-013 SHALL have ports full, empty  output  1 each, and count  output  $clog2(DEPTH)+1.
REQ-014 SHALL have ports fwd_addr  input  $clog2(NUM_REGS), fwd_hit  output  1, fwd_data  output  BUS_WIDTH.

Function
REQ-015 SHALL accept an entry {wb_addr, wb_data} at a rising edge where wb_valid && wb_ready.
REQ-016 SHALL hold wb_ready low when count == DEPTH; no push while full, even if a pop occurs that cycle.
REQ-017 SHALL pop the head at a rising edge where !empty && !stall_in, registering regWrite = one-hot(head addr) and rf_in = head data.
REQ-018 SHALL keep regWrite high for exactly one cycle per popped entry; regWrite = 0 when nothing popped; rf_in holds its last value.
REQ-019 SHALL give minimum latency of one cycle: entry pushed at edge N drives regWrite in cycle after edge N+1; register captures at edge N+2.
REQ-020 SHALL issue writes in strict FIFO order, including repeated writes to the same address.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-022 SHALL, while stall_in is high, hold head, issue no regWrite, and still accept pushes until full.
REQ-023 SHALL derive full = (count == DEPTH), empty = (count == 0), all registered-state based.

Reset
REQ-024 SHALL, on rst_n low, immediately clear pointers, count, regWrite and rf_in to 0 (empty=1, full=0, wb_ready=1).
REQ-025 SHALL discard all queued and in-flight entries on reset mid-operation; no regWrite pulse during or after reset release until a new push.

Configuration
REQ-026 SHALL, with macro RF_WB_QUEUE_FWD_EN defined, drive fwd_hit=1 and fwd_data = data of the newest entry matching fwd_addr among queued entries and the entry currently on regWrite/rf_in, combinationally.
REQ-027 SHALL, without RF_WB_QUEUE_FWD_EN, keep the fwd ports but tie fwd_hit=0 and fwd_data=0, with no match logic synthesised.

Structure
REQ-028 SHALL place default BUS_WIDTH, NUM_REGS, DEPTH constants and the queue-entry struct typedef (addr, data) in shared package rf_wb_pkg.
REQ-029 SHALL implement the index-to-one-hot conversion in sub-module rf_wb_dec.

Verification
REQ-030 SHALL verify: push {3, 16'h0F0F}, stall_in=0 -> regWrite=8'h08, rf_in=16'h0F0F for one cycle, two edges after push.
REQ-031 SHALL verify: stall_in=1, push 5 entries -> count=4, full=1, wb_ready=0, 5th not accepted, regWrite=0 throughout.
REQ-032 SHALL verify: full queue, release stall -> writes 0..3 issued on 4 consecutive cycles in push order, then empty=1.
REQ-033 SHALL verify: rst_n low while count=3 -> count=0, regWrite=0 asynchronously; no writes after release.
REQ-034 SHALL verify: push {2,16'hAAAA} then {2,16'hFFFF} with stall, fwd_addr=2 -> fwd_hit=1, fwd_data=16'hFFFF (FWD_EN) / fwd_hit=0 (without).
REQ-035 SHALL verify: continuous push and pop for 10 cycles -> count constant, pointers wrap, data order preserved.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared constants and the write-back queue entry type for rf_wb_queue.
package rf_wb_pkg;

    localparam int unsigned BUS_WIDTH_DEF = 16;
    localparam int unsigned NUM_REGS_DEF  = 8;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned ADDR_W_DEF    = $clog2(NUM_REGS_DEF);

    // One queued write-back: destination register index and its data
    typedef struct packed {
        logic [ADDR_W_DEF-1:0]    addr;
        logic [BUS_WIDTH_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_dec.sv
// Register index to one-hot write-enable decoder.
module rf_wb_dec
    import rf_wb_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic [$clog2(NUM_REGS)-1:0] idx_i,
    output logic [NUM_REGS-1:0]         onehot_c_o
);

    // Set exactly the bit selected by the index
    always_comb begin
        onehot_c_o        = '0;
        onehot_c_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rf_wb_queue.sv
// Write-back queue in front of a register file: buffers {addr, data} pushes
// and issues them in FIFO order as one-cycle one-hot regWrite pulses with the
// data on the shared rf_in bus. Holds issue while stall_in is high.
// Optional read forwarding is built only when RF_WB_QUEUE_FWD_EN is defined;
// otherwise fwd_hit/fwd_data are tied to zero.
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
    input  logic [BUS_WIDTH-1:0]        wb_data,
    input  logic                        stall_in,
    output logic [NUM_REGS-1:0]         regWrite,
    output logic [BUS_WIDTH-1:0]        rf_in,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    input  logic [$clog2(NUM_REGS)-1:0] fwd_addr,
    output logic                        fwd_hit,
    output logic [BUS_WIDTH-1:0]        fwd_data
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [ADDR_W-1:0]    addr_mem_q [DEPTH];
    logic [BUS_WIDTH-1:0] data_mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_REGS-1:0]  reg_write_q, reg_write_d;
    logic [BUS_WIDTH-1:0] rf_in_q, rf_in_d;

    logic                 full_c;
    logic                 empty_c;
    logic                 push_c;
    logic                 pop_c;
    logic [ADDR_W-1:0]    head_addr_c;
    logic [NUM_REGS-1:0]  head_onehot_c;

    // Status flags from registered occupancy; no push while full even on a pop
    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign empty_c     = (count_q == '0);
    assign push_c      = wb_valid && !full_c;
    assign pop_c       = !empty_c && !stall_in;
    assign head_addr_c = addr_mem_q[rd_ptr_q];

    rf_wb_dec #(
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .idx_i      (head_addr_c),
        .onehot_c_o (head_onehot_c)
    );

    // Next-state: pointer/count bookkeeping and one-cycle issue of the head
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        reg_write_d = '0;
        rf_in_d     = rf_in_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            reg_write_d = head_onehot_c;
            rf_in_d     = data_mem_q[rd_ptr_q];
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state and registered outputs; reset drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= '0;
            rf_in_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            rf_in_q     <= rf_in_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            addr_mem_q[wr_ptr_q] <= wb_addr;
            data_mem_q[wr_ptr_q] <= wb_data;
        end
    end

    assign wb_ready = !full_c;
    assign full     = full_c;
    assign empty    = empty_c;
    assign count    = count_q;
    assign regWrite = reg_write_q;
    assign rf_in    = rf_in_q;

`ifdef RF_WB_QUEUE_FWD_EN
    logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
    logic                 fwd_hit_c;
    logic [BUS_WIDTH-1:0] fwd_data_c;

    // Address of the entry currently presented on regWrite/rf_in
    always_comb begin
        bus_addr_d = bus_addr_q;
        if (pop_c) begin
            bus_addr_d = head_addr_c;
        end
    end

    // Track bus entry address alongside the issued write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr_q <= '0;
        end else begin
            bus_addr_q <= bus_addr_d;
        end
    end

    // Oldest-to-newest scan so the newest matching entry wins
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        if ((|reg_write_q) && (bus_addr_q == fwd_addr)) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = rf_in_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (addr_mem_q[rd_ptr_q + PTR_W'(i)] == fwd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_mem_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    assign fwd_hit  = fwd_hit_c;
    assign fwd_data = fwd_data_c;
`else
    logic unused_fwd_addr;

    // Forwarding disabled: ports kept, outputs tied off
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule
